// File: rtl/huc6280_pkg.sv
// Shared constants and types for the HuC6280 timer block.
package huc6280_pkg;

  localparam int unsigned TIMER_CNT_W    = 7;
  localparam int unsigned TIMER_PRESCALE = 1024;

  localparam logic TIMER_RELOAD = 1'b0;
  localparam logic TIMER_CTRL   = 1'b1;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/huc6280_timer_prescaler.sv
// clk_en-gated down counter with synchronous load and terminal-count flag.
module huc6280_timer_prescaler
  import huc6280_pkg::*;
#(
  parameter int unsigned PRESCALE = TIMER_PRESCALE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic tick_i,
  output logic tc_c
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] TOP_VAL = PW'(PRESCALE - 1);

  logic [PW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = TOP_VAL;
    end else if (tick_i) begin
      count_d = (count_q == '0) ? TOP_VAL : count_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= TOP_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_c = (count_q == '0);

endmodule

// File: rtl/huc6280_timer.sv
// HuC6280 interval timer: reload/control registers, 7-bit counter, irq flag.
module huc6280_timer
  import huc6280_pkg::*;
#(
  parameter int unsigned PRESCALE = TIMER_PRESCALE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic       cs,
  input  logic       we,
  input  logic       re,
  input  logic       addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       irq_ack,
  output logic       irq
);

  timer_state_e           state_q, state_d;
  logic [TIMER_CNT_W-1:0] reload_q, reload_d;
  logic [TIMER_CNT_W-1:0] counter_q, counter_d;
  logic                   irq_q, irq_d;
  logic [7:0]             rdata_q, rdata_d;

  logic wr_reload_c;
  logic wr_ctrl_c;
  logic rd_c;
  logic start_c;
  logic tick_c;
  logic pre_tc_c;
  logic underflow_c;
  logic unused_wdata_hi;

  assign wr_reload_c     = cs & we & (addr == TIMER_RELOAD);
  assign wr_ctrl_c       = cs & we & (addr == TIMER_CTRL);
  assign rd_c            = cs & re;
  assign unused_wdata_hi = wdata[7];

  // Run/stop control; start_c marks the enable rising edge
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (wr_ctrl_c && wdata[0]) begin
          state_d = ST_RUN;
          start_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (wr_ctrl_c && !wdata[0]) begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Start can only occur from STOP, so it never coincides with a tick
  assign tick_c = (state_q == ST_RUN) & clk_en;

  huc6280_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (start_c),
    .tick_i  (tick_c),
    .tc_c    (pre_tc_c)
  );

  assign underflow_c = tick_c & pre_tc_c & (counter_q == '0);

  always_comb begin
    reload_d  = reload_q;
    counter_d = counter_q;
    irq_d     = irq_q;
    rdata_d   = rdata_q;

    if (wr_reload_c) begin
      reload_d = wdata[TIMER_CNT_W-1:0];
    end

    // Restart takes the freshly written reload; underflow uses the latched one
    if (start_c) begin
      counter_d = reload_d;
    end else if (tick_c && pre_tc_c) begin
      counter_d = (counter_q == '0) ? reload_q : counter_q - TIMER_CNT_W'(1);
    end

    if (underflow_c) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end

    // Reads sample pre-write register values
    if (rd_c) begin
      if (addr == TIMER_CTRL) begin
        rdata_d = 8'(state_q == ST_RUN);
      end else begin
        rdata_d = 8'(counter_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reload_q  <= '0;
      counter_q <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      reload_q  <= reload_d;
      counter_q <= counter_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_huc6280_timer.sv
// Self-checking bench for huc6280_timer with PRESCALE=4.
module tb_huc6280_timer;

  localparam int P = 4;

  logic       clk;
  logic       reset_n;
  logic       clk_en;
  logic       cs;
  logic       we;
  logic       re;
  logic       addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq_ack;
  logic       irq;

  huc6280_timer #(.PRESCALE(P)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .cs      (cs),
    .we      (we),
    .re      (re),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_ack (irq_ack),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: m_left = clk_en pulses remaining until the next underflow.
  // The visible counter is derived as (m_left-1)/P.
  int m_left;
  int m_reload;
  bit m_en;
  bit m_irq;
  int m_rdata;

  typedef struct {
    logic       cs;
    logic       we;
    logic       re;
    logic       addr;
    logic [7:0] wdata;
    logic       clk_en;
    logic       ack;
    logic [7:0] exp_rdata;
    logic       exp_irq;
    string      name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r_n, input bit ce, input bit c, input bit w,
                              input bit r, input bit a, input logic [7:0] d, input bit ack);
    bit ul;
    int new_reload;
    bit new_en;
    if (!r_n) begin
      m_reload = 0;
      m_en     = 0;
      m_left   = P;
      m_irq    = 0;
      m_rdata  = 0;
    end else begin
      if (c && r) m_rdata = a ? int'(m_en) : (m_left - 1) / P;
      ul         = m_en && ce && (m_left == 1);
      new_reload = (c && w && !a) ? int'(d) % 128 : m_reload;
      new_en     = (c && w && a) ? d[0] : m_en;
      if (!m_en && new_en)  m_left = (new_reload + 1) * P;
      else if (m_en && ce)  m_left = (m_left == 1) ? (m_reload + 1) * P : m_left - 1;
      if (ul)       m_irq = 1;
      else if (ack) m_irq = 0;
      m_reload = new_reload;
      m_en     = new_en;
    end
  endtask

  task automatic step(input bit r_n, input bit ce, input bit c, input bit w,
                      input bit r, input bit a, input logic [7:0] d, input bit ack);
    reset_n = r_n;
    clk_en  = ce;
    cs      = c;
    we      = w;
    re      = r;
    addr    = a;
    wdata   = d;
    irq_ack = ack;
    @(posedge clk);
    model_update(r_n, ce, c, w, r, a, d, ack);
    #1;
    check("model_rdata", int'(rdata), m_rdata);
    check("model_irq", int'(irq), int'(m_irq));
  endtask

  task automatic cyc(input bit ce, input bit ack);
    step(1'b1, ce, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, ack);
  endtask

  task automatic rd(input bit a, input bit ce);
    step(1'b1, ce, 1'b1, 1'b0, 1'b1, a, 8'h00, 1'b0);
  endtask

  task automatic wr(input bit a, input logic [7:0] d, input bit ce);
    step(1'b1, ce, 1'b1, 1'b1, 1'b0, a, d, 1'b0);
  endtask

  initial begin
    // cs we re addr wdata clk_en ack exp_rdata exp_irq
    vecs[0] = '{1, 0, 1, 1, 8'h00, 0, 0, 8'h00, 0, "rst_rd_ctrl"};
    vecs[1] = '{1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, "rst_rd_count"};
    vecs[2] = '{1, 1, 0, 0, 8'h82, 0, 0, 8'h00, 0, "wr_reload"};
    vecs[3] = '{1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, "count_unaffected"};
    vecs[4] = '{0, 1, 1, 1, 8'h01, 1, 0, 8'h00, 0, "no_cs_ignored"};
    vecs[5] = '{1, 0, 1, 1, 8'h00, 0, 0, 8'h00, 0, "still_stopped"};
    vecs[6] = '{1, 1, 0, 1, 8'hFE, 0, 0, 8'h00, 0, "ctrl_bit0_only"};
    vecs[7] = '{1, 1, 1, 1, 8'h01, 0, 0, 8'h00, 0, "rd_wr_prewrite"};
    vecs[8] = '{1, 0, 1, 1, 8'h00, 0, 0, 8'h01, 0, "enabled"};
    vecs[9] = '{1, 0, 1, 0, 8'h00, 0, 0, 8'h02, 0, "count_loaded"};

    reset_n = 1'b0; clk_en = 1'b0; cs = 1'b0; we = 1'b0; re = 1'b0;
    addr = 1'b0; wdata = 8'h00; irq_ack = 1'b0;
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1);
    check("reset_rdata", int'(rdata), 0);
    check("reset_irq", int'(irq), 0);

    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].clk_en, vecs[i].cs, vecs[i].we, vecs[i].re,
           vecs[i].addr, vecs[i].wdata, vecs[i].ack);
      check({vecs[i].name, "_rdata"}, int'(rdata), int'(vecs[i].exp_rdata));
      check({vecs[i].name, "_irq"}, int'(irq), int'(vecs[i].exp_irq));
    end

    // Basic countdown from reload=2, read counter on each pulse
    for (int k = 1; k <= 12; k++) begin
      rd(1'b0, 1'b1);
      check("countdown_val", int'(rdata), 2 - (k - 1) / 4);
      check("countdown_irq", int'(irq), (k == 12) ? 1 : 0);
    end
    rd(1'b0, 1'b0);
    check("count_reloaded", int'(rdata), 2);

    // Acknowledge, then acknowledge coinciding with underflow
    cyc(1'b0, 1'b1);
    check("ack_clears", int'(irq), 0);
    for (int k = 0; k < 11; k++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    check("ack_in_underflow", int'(irq), 1);
    cyc(1'b0, 1'b1);
    check("ack_after", int'(irq), 0);

    // Rewriting enable=1 mid-count at counter=1 must not restart
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0);
    wr(1'b1, 8'h01, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    rd(1'b0, 1'b0);
    check("no_restart", int'(rdata), 1);
    cyc(1'b1, 1'b0);
    rd(1'b0, 1'b0);
    check("no_restart_dec", int'(rdata), 0);

    // Disable holds; re-enable together with clk_en restarts without decrement
    wr(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rd(1'b0, 1'b0);
    check("stop_hold", int'(rdata), 0);
    rd(1'b1, 1'b0);
    check("stop_rd_ctrl", int'(rdata), 0);
    wr(1'b1, 8'h01, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    rd(1'b0, 1'b0);
    check("restart_no_dec", int'(rdata), 2);
    cyc(1'b1, 1'b0);
    rd(1'b0, 1'b0);
    check("restart_presc", int'(rdata), 1);

    // Gapped clk_en with reload=0
    wr(1'b1, 8'h00, 1'b0);
    wr(1'b0, 8'h00, 1'b0);
    wr(1'b1, 8'h01, 1'b0);
    for (int p = 1; p <= 4; p++) begin
      cyc(1'b1, 1'b0);
      check("gap_irq", int'(irq), (p == 4) ? 1 : 0);
      if (p < 4) begin
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
      end
    end
    cyc(1'b0, 1'b1);
    check("gap_ack", int'(irq), 0);

    // Reload write mid-count only applies at the next underflow
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    wr(1'b0, 8'h05, 1'b0);
    rd(1'b0, 1'b0);
    check("reload_defer", int'(rdata), 0);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("reload_defer_irq", int'(irq), 1);
    rd(1'b0, 1'b0);
    check("reload_applied", int'(rdata), 5);

    // Reset mid-count at counter=1 aborts with no irq
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0);
    rd(1'b0, 1'b0);
    check("pre_reset_count", int'(rdata), 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
    check("reset_prio_rdata", int'(rdata), 0);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 1'b0);
      check("rst_abort_irq", int'(irq), 0);
    end
    rd(1'b1, 1'b0);
    check("rst_enable_0", int'(rdata), 0);
    rd(1'b0, 1'b0);
    check("rst_count_0", int'(rdata), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) d = d & 8'h83;
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1),
           d,
           ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
